// File: rtl/des_display_pager.sv
// Pages a latched 64-bit DES block onto a 16-bit display bus, one word at a time.
// Define DES_PAGER_AUTOSCROLL_EN to compile in the auto-scroll timer and hold control.
module des_display_pager #(
  parameter logic [31:0] TICKS_PER_PAGE = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] blk_in,
  input  logic        blk_valid,
  input  logic        next_btn,
  input  logic        hold,
  output logic [15:0] val,
  output logic [1:0]  page,
  output logic        loaded
);

  typedef enum logic {EMPTY, SHOW} state_t;

  state_t      state_q, state_d;
  logic [63:0] blk_q, blk_d;
  logic [15:0] val_q, val_d;
  logic [1:0]  page_q, page_d;
  logic        loaded_q, loaded_d;
  logic        btn_prev_q, btn_prev_d;
  logic        btn_rise;
  logic        expire;
  logic        do_load, do_adv;

  function automatic logic [15:0] sel_word(input logic [63:0] b, input logic [1:0] p);
    case (p)
      2'd0:    sel_word = b[63:48];
      2'd1:    sel_word = b[47:32];
      2'd2:    sel_word = b[31:16];
      default: sel_word = b[15:0];
    endcase
  endfunction

  assign btn_rise = next_btn & ~btn_prev_q;

`ifdef DES_PAGER_AUTOSCROLL_EN
  logic [31:0] timer_q, timer_d;

  // A held counter sitting at the terminal value must not fire.
  assign expire = ~hold && (timer_q == TICKS_PER_PAGE - 32'd1);

  always_comb begin
    timer_d = timer_q;
    if (state_q == EMPTY || do_load || do_adv) timer_d = '0;
    else if (!hold)                            timer_d = timer_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign expire      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    val_d      = val_q;
    page_d     = page_q;
    loaded_d   = loaded_q;
    btn_prev_d = next_btn;
    do_load    = 1'b0;
    do_adv     = 1'b0;

    // Load outranks button, button outranks timer; losers are dropped.
    case (state_q)
      EMPTY:   do_load = blk_valid;
      default: begin
        if (blk_valid)                do_load = 1'b1;
        else if (btn_rise || expire)  do_adv  = 1'b1;
      end
    endcase

    if (do_load) begin
      state_d  = SHOW;
      blk_d    = blk_in;
      page_d   = 2'd0;
      val_d    = blk_in[63:48];
      loaded_d = 1'b1;
    end else if (do_adv) begin
      page_d = page_q + 2'd1;
      val_d  = sel_word(blk_q, page_q + 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      blk_q      <= '0;
      val_q      <= '0;
      page_q     <= '0;
      loaded_q   <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      val_q      <= val_d;
      page_q     <= page_d;
      loaded_q   <= loaded_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  assign val    = val_q;
  assign page   = page_q;
  assign loaded = loaded_q;

endmodule

// File: tb/tb_des_display_pager.sv
// Table-driven bench for des_display_pager with an expected-result queue.
module tb_des_display_pager;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] blk_in;
  logic        blk_valid;
  logic        next_btn;
  logic        hold;
  logic [15:0] val;
  logic [1:0]  page;
  logic        loaded;

  always #5 clk = ~clk;

  des_display_pager #(.TICKS_PER_PAGE(32'd4)) dut (
    .clk(clk), .rst(rst), .blk_in(blk_in), .blk_valid(blk_valid),
    .next_btn(next_btn), .hold(hold), .val(val), .page(page), .loaded(loaded)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        vld;
    logic [63:0] blk;
    logic        btn;
    logic        hold;
    logic [15:0] e_val;
    logic [1:0]  e_page;
    logic        e_loaded;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] v;
    logic [1:0]  p;
    logic        l;
  } exp_t;

  localparam logic [63:0] B1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] B2 = 64'hFEDC_BA98_7654_3210;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string n, logic r, logic v, logic [63:0] b, logic bt,
                              logic h, logic [15:0] ev, logic [1:0] ep, logic el);
    vec_t t;
    t.name = n; t.rst = r; t.vld = v; t.blk = b; t.btn = bt; t.hold = h;
    t.e_val = ev; t.e_page = ep; t.e_loaded = el;
    return t;
  endfunction

  function automatic logic [15:0] word(input logic [63:0] b, input logic [1:0] p);
    case (p)
      2'd0:    word = b[63:48];
      2'd1:    word = b[47:32];
      2'd2:    word = b[31:16];
      default: word = b[15:0];
    endcase
  endfunction

  task automatic run(input vec_t t);
    exp_t e, got;
    rst = t.rst; blk_valid = t.vld; blk_in = t.blk; next_btn = t.btn; hold = t.hold;
    e.name = t.name; e.v = t.e_val; e.p = t.e_page; e.l = t.e_loaded;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    if (val !== got.v || page !== got.p || loaded !== got.l) begin
      errors++;
      $display("FAIL %s: got val=%h page=%0d loaded=%b, want val=%h page=%0d loaded=%b",
               got.name, val, page, loaded, got.v, got.p, got.l);
    end
  endtask

  initial begin
    int tc;
    logic [1:0] pg;
    logic h;
    rst = 1'b1; blk_valid = 1'b0; blk_in = '0; next_btn = 1'b0; hold = 1'b1;

    // hold=1 keeps any compiled-in timer frozen during the manual tests
    vecs.push_back(mk("reset",        1, 0, 64'h0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("idle_empty",   0, 0, 64'h0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("btn_empty",    0, 0, 64'h0, 1, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("btn_rel_emp",  0, 0, 64'h0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("load_b1",      0, 1, B1,    0, 1, 16'h0123, 0, 1));
    vecs.push_back(mk("press1",       0, 0, 64'h0, 1, 1, 16'h4567, 1, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("gap1", 0, 0, 64'h0, 0, 1, 16'h4567, 1, 1));
    vecs.push_back(mk("press2",       0, 0, 64'h0, 1, 1, 16'h89AB, 2, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("gap2", 0, 0, 64'h0, 0, 1, 16'h89AB, 2, 1));
    vecs.push_back(mk("press3",       0, 0, 64'h0, 1, 1, 16'hCDEF, 3, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("gap3", 0, 0, 64'h0, 0, 1, 16'hCDEF, 3, 1));
    vecs.push_back(mk("press4_wrap",  0, 0, 64'h0, 1, 1, 16'h0123, 0, 1));
    vecs.push_back(mk("gap4",         0, 0, 64'h0, 0, 1, 16'h0123, 0, 1));
    vecs.push_back(mk("held_first",   0, 0, 64'h0, 1, 1, 16'h4567, 1, 1));
    for (int i = 0; i < 9; i++) vecs.push_back(mk("held_btn", 0, 0, 64'h0, 1, 1, 16'h4567, 1, 1));
    vecs.push_back(mk("held_rel",     0, 0, 64'h0, 0, 1, 16'h4567, 1, 1));
    vecs.push_back(mk("load_vs_btn",  0, 1, B2,    1, 1, 16'hFEDC, 0, 1));
    vecs.push_back(mk("rel_b2",       0, 0, 64'h0, 0, 1, 16'hFEDC, 0, 1));
    vecs.push_back(mk("b2_press1",    0, 0, 64'h0, 1, 1, 16'hBA98, 1, 1));
    vecs.push_back(mk("b2_rel1",      0, 0, 64'h0, 0, 1, 16'hBA98, 1, 1));
    vecs.push_back(mk("b2_press2",    0, 0, 64'h0, 1, 1, 16'h7654, 2, 1));
    vecs.push_back(mk("rst_in_show",  1, 0, 64'h0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("post_rst",     0, 0, 64'h0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("btn_after_rst",0, 0, 64'h0, 1, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("rel_after_rst",0, 0, 64'h0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("reload_b1",    0, 1, B1,    0, 1, 16'h0123, 0, 1));

    foreach (vecs[i]) run(vecs[i]);

`ifdef DES_PAGER_AUTOSCROLL_EN
    // Reference scroll model: advance on the edge where the count sits at 3.
    run(mk("auto_load", 0, 1, B1, 0, 0, 16'h0123, 0, 1));
    tc = 0; pg = 2'd0;
    for (int n = 0; n < 40; n++) begin
      h = (n >= 13 && n < 19);
      if (!h) begin
        if (tc == 3) begin pg = pg + 2'd1; tc = 0; end
        else tc++;
      end
      run(mk("auto_scroll", 0, 0, 64'h0, 0, h, word(B1, pg), pg, 1));
    end
`else
    tc = 0; pg = 2'd0; h = 1'b0;
    run(mk("noauto_load", 0, 1, B1, 0, h, 16'h0123, pg, 1));
    for (int n = 0; n < 100; n++)
      run(mk("noauto_static", 0, 0, 64'h0, 0, 0, word(B1, pg), pg, 1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
